// File: rtl/icache_tag_ctrl.sv
// icache_tag_ctrl: owns the per-way icache tag/valid RAMs and serves lookups,
// refills, single-line invalidates and invalidate-all sweeps. After reset the
// controller clears every valid bit before it accepts any request.
//   Latency: LOOKUP responds 1 cycle after accept; REFILL/INV_LINE after 1
//   (DONE cycle); INV_ALL after LINE+1 cycles.
//   Backpressure: req_ready only in IDLE; req_* are ignored otherwise.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid/ready   - request handshake; req_op/req_addr/req_way payload
//   rsp_valid/hit/way - one-cycle completion pulse with lookup result
//   ram_*             - shared index, per-way write strobes, write data
//   ram_back          - registered RAM read, {tag, valid} per way

module icache_tag_ctrl #(
  parameter  int LINE  = 128,
  parameter  int WAYS  = 2,
  parameter  int OFF_W = 5,
  localparam int IDX_W = $clog2(LINE),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [31:0]        req_addr,
  input  logic [WAY_W-1:0]   req_way,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [WAY_W-1:0]   rsp_way,
  output logic               ram_en,
  output logic [IDX_W-1:0]   ram_index,
  output logic [WAYS-1:0]    ram_tagwen,
  output logic [WAYS-1:0]    ram_valwen,
  output logic [19:0]        ram_wtag,
  output logic               ram_wvalid,
  input  logic [21*WAYS-1:0] ram_back
);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_LOOKUP = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_SWEEP  = 3'd4;

  localparam logic [1:0] OP_LOOKUP   = 2'd0;
  localparam logic [1:0] OP_REFILL   = 2'd1;
  localparam logic [1:0] OP_INV_LINE = 2'd2;
  localparam logic [1:0] OP_INV_ALL  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [19:0]      tag_q, tag_d;

  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic [19:0]      req_tag;
  logic [WAYS-1:0]  way_sel;
  logic [WAYS-1:0]  way_hit;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             unused_addr;

  assign req_idx     = req_addr[IDX_W+OFF_W-1:OFF_W];
  assign req_tag     = req_addr[31:12];
  // Byte-offset bits never matter to the tag array.
  assign unused_addr = ^req_addr[OFF_W-1:0];

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;

  // One-hot target way; an out-of-range req_way selects nothing so the op
  // still completes without touching the arrays.
  always_comb begin
    way_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (int'(req_way) == w) way_sel[w] = 1'b1;
    end
  end

  // Tag compare against the registered read; lowest hitting way wins.
  always_comb begin
    way_hit = '0;
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = ram_back[21*w] & (ram_back[21*w+1 +: 20] == tag_q);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Response outputs are pure decodes of state, so async reset clears them
  // immediately.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    rsp_way   = '0;
    if (state_q == ST_LOOKUP) begin
      rsp_valid = 1'b1;
      rsp_hit   = hit_any;
      rsp_way   = hit_way;
    end else if (state_q == ST_DONE) begin
      rsp_valid = 1'b1;
    end
  end

  // RAM drive. In IDLE the index follows req_addr so the RAM samples it at
  // the accept edge; refill/invalidate writes also land on that edge.
  always_comb begin
    ram_en     = 1'b1;
    ram_index  = idx_q;
    ram_tagwen = '0;
    ram_valwen = '0;
    ram_wtag   = '0;
    ram_wvalid = 1'b0;
    case (state_q)
      ST_INIT, ST_SWEEP: begin
        ram_index  = cnt_q;
        ram_valwen = '1;
      end
      ST_IDLE: begin
        ram_index = req_idx;
        if (accept && req_op == OP_REFILL) begin
          ram_tagwen = way_sel;
          ram_valwen = way_sel;
          ram_wtag   = req_tag;
          ram_wvalid = 1'b1;
        end else if (accept && req_op == OP_INV_LINE) begin
          ram_valwen = way_sel;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    case (state_q)
      ST_INIT, ST_SWEEP: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = (state_q == ST_INIT) ? ST_IDLE : ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          idx_d = req_idx;
          case (req_op)
            OP_LOOKUP: begin
              tag_d   = req_tag;
              state_d = ST_LOOKUP;
            end
            OP_INV_ALL: state_d = ST_SWEEP;
            default:    state_d = ST_DONE;
          endcase
        end
      end
      ST_LOOKUP: state_d = ST_IDLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: doc/icache_tag_ctrl.md
Name: icache_tag_ctrl

Overview:
- Owns the per-way instruction-cache tag/valid RAMs: drives index, write enables and write data, and consumes the 1-cycle-latency registered read result {tag[19:0], valid}.
- Serves the icache datapath with four operations: tag lookup (hit/way), refill tag write, single-line invalidate, and invalidate-all sweep.
- After reset, performs an automatic valid-clear sweep of every line before accepting any request.

Parameters:
- LINE, 128, lines per way; power of 2; IDX_W = $clog2(LINE)
- WAYS, 2, number of ways (1..4)
- OFF_W, 5, byte-offset bits per line; IDX_W + OFF_W must equal 12 (tag = addr[31:12])

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_op  in  2  0=LOOKUP 1=REFILL 2=INV_LINE 3=INV_ALL
- req_addr  in  32  physical address; index = addr[IDX_W+OFF_W-1:OFF_W], tag = addr[31:12]
- req_way  in  $clog2(WAYS) (min 1)  target way for REFILL / INV_LINE
- rsp_valid  out  1  one-cycle completion pulse
- rsp_hit  out  1  LOOKUP hit (0 for other ops)
- rsp_way  out  $clog2(WAYS) (min 1)  hitting way (0 on miss/other ops)
- ram_en  out  1  RAM enable, 1 whenever index is driven
- ram_index  out  IDX_W  RAM index, shared by all ways
- ram_tagwen  out  WAYS  per-way tag write enable
- ram_valwen  out  WAYS  per-way valid write enable
- ram_wtag  out  20  tag write data
- ram_wvalid  out  1  valid write data
- ram_back  in  21*WAYS  way w at [21w+20:21w], format {tag[19:0], valid}; reflects index sampled at previous edge

Behaviour:
- States: INIT, IDLE, LOOKUP, DONE, SWEEP.
- Reset (async, any state, including mid-sweep): state=INIT, sweep counter=0, rsp_valid=0, rsp_hit=0, rsp_way=0, req_ready=0.
- All RAM write strobes are 0 outside the cycles listed below.
- req_ready = 1 only in IDLE. A request is accepted at a rising edge with req_valid & req_ready.
- ram_index:
  - In IDLE: combinationally = req_addr index (RAM samples it at the accept edge).
  - In INIT/SWEEP: = counter.
  - Otherwise: held at the latched index.
- INIT: each cycle, ram_valwen = all ones, ram_wvalid = 0, ram_tagwen = 0, index = counter; counter increments. When counter = LINE-1 is written: counter -> 0, state -> IDLE. Takes exactly LINE cycles. No rsp_valid.
- LOOKUP (op 0):
  - Accept edge: latch tag; IDLE -> LOOKUP.
  - In LOOKUP: compare each way: hit_w = back_w[0] & (back_w[20:1] == latched tag).
  - rsp_valid = 1 in this same cycle (combinational from ram_back), rsp_hit = OR of hit_w, rsp_way = lowest hitting way (0 on miss).
  - Next state IDLE. Latency: response in cycle after acceptance; throughput 1 per 2 cycles.
- REFILL (op 1): during the IDLE accept cycle, combinationally assert ram_tagwen[req_way] = ram_valwen[req_way] = 1, ram_wtag = addr tag, ram_wvalid = 1. Write lands at accept edge. Next state DONE.
- INV_LINE (op 2): during the accept cycle, ram_valwen[req_way] = 1, ram_wvalid = 0, no tag write. Next state DONE.
- DONE: rsp_valid = 1, rsp_hit = 0, rsp_way = 0 for one cycle, then IDLE.
- INV_ALL (op 3): accept -> SWEEP; same write pattern as INIT. After the final line is written, go to DONE, so rsp_valid pulses once, LINE+1 cycles after acceptance.
- Read/write collision: the RAM returns pre-write data for a same-index read in the write cycle. This is only reachable via back-to-back ops; a LOOKUP accepted right after a REFILL completes reads the new tag (DONE cycle separates them).
- req_way >= WAYS: no write enables asserted, still completes via DONE.
- Multi-way hit: not flagged; lowest way wins.
- req_op/req_addr are ignored when req_ready = 0.

Test Plan:
- Reset, hold req_valid=1 op=LOOKUP -> req_ready stays 0 for 128 cycles with ram_valwen=2'b11 and index 0..127, then 1; every ram_back valid bit reads 0 afterwards.
- REFILL addr=0x1234_5F40 way 1 -> ram_tagwen=2'b10, wtag=0x12345, index=0x7A; LOOKUP same addr -> rsp_valid next cycle, rsp_hit=1, rsp_way=1.
- LOOKUP 0x1234_6F40 (same index, tag 0x12346) -> rsp_hit=0, rsp_way=0; INV_LINE 0x1234_5F40 way 1 then LOOKUP 0x1234_5F40 -> rsp_hit=0.
- Refill both ways at index 5 with different tags, INV_ALL -> rsp_valid exactly 129 cycles after accept, single pulse; then lookups of both tags miss.
- Assert rst for 1 cycle at sweep counter 60 of INV_ALL -> outputs reset immediately, INIT restarts at index 0, full 128-cycle INIT, no rsp_valid pulse.
- Back-to-back REFILL (way 0) then LOOKUP of same line with req_valid held -> second accept only after DONE; lookup hits way 0.
